// File: rtl/load_unit_pkg.sv
// load_unit_pkg: shared load/store select encodings, FSM states and span detection
package load_unit_pkg;
    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b100,
        LD_HU = 3'b101
    } load_sel_e;
    typedef enum logic [2:0] {
        ST_B = 3'b000,
        ST_H = 3'b001,
        ST_W = 3'b010
    } store_sel_e;
    typedef enum logic [1:0] {IDLE, SPAN, RESP} state_e;
    // Illegal selects never span, so only the three legal multi-byte loads matter here.
    function automatic logic is_span(input logic [2:0] sel, input logic [1:0] off);
        return ((sel == LD_H || sel == LD_HU) && off == 2'b11) || (sel == LD_W && off != 2'b00);
    endfunction
endpackage

// File: rtl/load_unit_if.sv
// load_unit_if: request, memory read port and response signals of the load unit
interface load_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [2:0]            load_sel;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    modport master (
        output req_valid, req_addr, load_sel, mem_rd_data, rsp_ready,
        input  req_ready, mem_rd_addr, rsp_valid, rsp_data, rsp_err
    );
    modport slave (
        input  req_valid, req_addr, load_sel, mem_rd_data, rsp_ready,
        output req_ready, mem_rd_addr, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/load_unit_align_ext.sv
// load_align_ext: shifts the two-word window by the byte offset and sign/zero-extends
module load_align_ext
    import load_unit_pkg::*;
(
    input  logic [63:0] words,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_sel,
    output logic [31:0] data,
    output logic        illegal
);
    logic [63:0] sh;
    assign sh = words >> {offset, 3'b000};
    always_comb begin
        illegal = !(load_sel == LD_B || load_sel == LD_H || load_sel == LD_W ||
                    load_sel == LD_BU || load_sel == LD_HU);
        data = load_sel == LD_B  ? {{24{sh[7]}}, sh[7:0]} :
               load_sel == LD_BU ? {24'd0, sh[7:0]} :
               load_sel == LD_H  ? {{16{sh[15]}}, sh[15:0]} :
               load_sel == LD_HU ? {16'd0, sh[15:0]} :
               load_sel == LD_W  ? sh[31:0] : 32'd0;
    end
endmodule

// File: rtl/load_unit.sv
// load_unit: RV32I load path with word-aligned reads and optional split of spanning loads
module load_unit
    import load_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter bit SPLIT_EN   = 1'b1
) (
    input logic clk,
    input logic rst_n,
    load_unit_if.slave bus
);
    state_e                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            sel;
    logic [DATA_WIDTH-1:0] word0;
    logic [31:0]           ext_data;
    logic                  ext_illegal;
    logic                  span_req;
    logic                  in_span;
    assign in_span  = state == SPAN;
    assign span_req = is_span(bus.load_sel, bus.req_addr[1:0]);
    assign bus.req_ready = state == IDLE;
    assign bus.mem_rd_addr = in_span ? {addr[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4)
                                     : {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
    // One extractor serves both the accept edge (word1 = 0) and the second read in SPAN.
    load_align_ext u_ext (
        .words    (in_span ? {bus.mem_rd_data, word0} : {32'd0, bus.mem_rd_data}),
        .offset   (in_span ? addr[1:0] : bus.req_addr[1:0]),
        .load_sel (in_span ? sel : bus.load_sel),
        .data     (ext_data),
        .illegal  (ext_illegal)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            sel           <= '0;
            word0         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    addr  <= bus.req_addr;
                    sel   <= bus.load_sel;
                    word0 <= bus.mem_rd_data;
                    if (span_req && SPLIT_EN) begin
                        state <= SPAN;
                    end else begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= span_req ? '0 : ext_data;
                        bus.rsp_err   <= span_req | ext_illegal;
                    end
                end
                SPAN: begin
                    state         <= RESP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_data  <= ext_data;
                    bus.rsp_err   <= 1'b0;
                end
                RESP: if (bus.rsp_ready) begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
Read-side companion to the byte-maskable data memory. It accepts RV32I load requests (lb/lh/lw/lbu/lhu) and issues word-aligned reads to the memory's combinational read port. It extracts the addressed byte or halfword and sign- or zero-extends it. Misaligned accesses that span two words are split into two sequential word reads. It sits between the CPU load path and the data memory read port.

Parameters:
ADDR_WIDTH, 32, byte-address width.
DATA_WIDTH, 32, word width; only 32 is supported.
SPLIT_EN, 1, 1 = misaligned spanning loads are split into two reads; 0 = spanning loads complete with rsp_err=1.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous reset, active low.
req_valid  input  1  load request present.
req_ready  output  1  unit can accept a request; high only in IDLE.
req_addr  input  ADDR_WIDTH  byte address.
load_sel  input  3  funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
mem_rd_addr  output  ADDR_WIDTH  word-aligned read address to memory; low 2 bits are always 0.
mem_rd_data  input  DATA_WIDTH  combinational read data for mem_rd_addr.
rsp_valid  output  1  response valid; held until accepted.
rsp_ready  input  1  consumer accepts the response.
rsp_data  output  DATA_WIDTH  extended load result.
rsp_err  output  1  illegal load_sel, or spanning access with SPLIT_EN=0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rsp_valid=0; rsp_data=0; rsp_err=0.
  - Internal address, size and word0 registers are cleared to 0.
  - req_ready=1 one delta after reset completes.
  - Reset asserted in any state aborts the operation with no response.
- FSM states: IDLE, SPAN, RESP.
- IDLE:
  - req_ready=1; mem_rd_addr = {req_addr[31:2],2'b00}.
  - Accept on req_valid && req_ready: latch addr, load_sel and word0 = mem_rd_data.
  - A load spans when it is lh/lhu with addr[1:0]=11, or lw with addr[1:0]!=00.
  - Spanning and SPLIT_EN=1 -> SPAN.
  - Otherwise, at the accept edge, compute rsp_data/rsp_err and go to RESP.
- SPAN:
  - mem_rd_addr = latched aligned addr + 4, wrapping modulo 2^ADDR_WIDTH.
  - Capture word1 = mem_rd_data, compute the result, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are stable.
  - On rsp_ready go to IDLE and clear rsp_valid at that edge; the next request can be accepted in the following cycle.
- Latency, accept edge to rsp_valid high:
  - non-spanning: 1 cycle.
  - spanning: 2 cycles.
  - Throughput: at most one load per 2 cycles.
- Result arithmetic:
  - Little-endian. sh = ({word1,word0} >> (8*addr[1:0])), 64 bits; word1 = 0 when not spanning.
  - lb: sign-extend sh[7:0]. lbu: zero-extend sh[7:0].
  - lh: sign-extend sh[15:0]. lhu: zero-extend sh[15:0].
  - lw: sh[31:0].
- Error rules:
  - Illegal load_sel (011, 110, 111): request is accepted, never spans, rsp_data=0, rsp_err=1.
  - Spanning with SPLIT_EN=0: rsp_data=0, rsp_err=1, no second read.
- Outside IDLE, req_valid is ignored; the requester must hold it.
- Address wrap: aligned 0xFFFFFFFC + 4 gives second read at 0x00000000.
- mem_rd_addr is purely combinational from state and inputs.

Decomposition:
- Shared package holds:
  - load_sel encodings: LD_B, LD_H, LD_W, LD_BU, LD_HU.
  - FSM state enum: IDLE, SPAN, RESP.
  - store_sel encodings, so store and load decode share one source.
- One natural combinational sub-module, load_align_ext: inputs {word1,word0}, offset and load_sel; outputs the extended data and the illegal flag. The top keeps the FSM and the handshake.

Test Plan:
- Memory model: mem[0x10]=0x80FF7F01, mem[0x14]=0x11223344; rsp_ready=1 unless noted.
- Byte loads: lb@0x11 -> 0x0000007F; lb@0x12 -> 0xFFFFFFFF; lbu@0x13 -> 0x00000080. For each, rsp_valid is high 1 cycle after accept and mem_rd_addr=0x10.
- Halfword and word loads: lh@0x12 -> 0xFFFF80FF; lhu@0x12 -> 0x000080FF; lw@0x10 -> 0x80FF7F01; all with rsp_err=0.
- Spanning loads:
  - lw@0x13: mem_rd_addr 0x10 then 0x14; rsp_data=0x22334480, 2 cycles after accept.
  - lh@0x13 -> 0x00004480.
  - With SPLIT_EN=0, lw@0x13 -> rsp_err=1, rsp_data=0, single read.
- Backpressure and illegal select:
  - Hold rsp_ready=0 for 3 cycles: rsp_valid, rsp_data and rsp_err are stable and req_ready=0.
  - load_sel=011 -> rsp_err=1, rsp_data=0.
- Reset and wrap:
  - Assert rst_n=0 while in SPAN: rsp_valid=0 immediately, no response is produced, req_ready=1 after release.
  - lw@0xFFFFFFFE: second read at 0x00000000.
